multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control sequencer for the RISC-V core, replacing the single-cycle decode-everything-at-once control.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives the instruction/data memory handshakes, the IR/PC/register-file write enables, the operand and writeback muxes, and the immediate-generator type select.
- Traps on an illegal opcode or a memory timeout, and counts retired instructions.

Parameters:
- MEM_TIMEOUT, 255: maximum cycles spent waiting for i_imem_ack or i_dmem_ack before trapping. Legal range is 1 to 255.

Ports:
- i_clk  in  1  core clock; all state changes on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_opcode  in  7  opcode field of the IR; stable from DECODE through WB.
- i_imem_ack  in  1  instruction memory data valid.
- i_dmem_ack  in  1  data memory access complete.
- i_br_taken  in  1  branch comparator result; valid in EXEC.
- o_imem_req  out  1  instruction fetch request.
- o_ir_we  out  1  IR load enable.
- o_pc_we  out  1  PC update enable.
- o_pc_sel  out  1  PC source: 0 = PC+4, 1 = ALU target.
- o_rf_we  out  1  register-file write enable.
- o_dmem_req  out  1  data memory request.
- o_dmem_we  out  1  data memory write (store).
- o_imm_sel  out  3  immediate type: 000 I, 001 S, 010 B, 011 U, 100 J.
- o_op_a_sel  out  2  ALU operand A: 00 rs1, 01 PC, 10 zero.
- o_op_b_sel  out  1  ALU operand B: 0 rs2, 1 immediate.
- o_wb_sel  out  2  writeback source: 00 ALU, 01 memory, 10 PC+4.
- o_trap  out  1  core halted.
- o_trap_cause  out  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout.
- o_retired  out  32  retired-instruction counter.
- o_state  out  3  current state, for debug.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=7.
- Outputs are combinational from the registered state and i_opcode; o_retired, o_trap and o_trap_cause are registered.
- Reset (asynchronous, at any time, including mid-access):
  - state = IDLE, o_retired = 0, o_trap_cause = 00, wait counter = 0.
  - All outputs are 0 while in IDLE.
- IDLE: always goes to FETCH on the next cycle.
- FETCH:
  - o_imem_req = 1.
  - On i_imem_ack: o_ir_we = 1 in the same cycle; next state DECODE.
- DECODE:
  - o_imm_sel is driven from i_opcode; it is also held in EXEC, MEM and WB.
  - Opcode to immediate type: LOAD, OP-IMM and JALR use I; STORE uses S; BRANCH uses B; LUI and AUIPC use U; JAL uses J; OP uses 000.
  - Any other opcode: next state TRAP with cause 01.
  - Otherwise: next state EXEC.
- EXEC, operand selects and next state by opcode:
  - OP: op_a 00, op_b 0. Next WB.
  - OP-IMM: op_a 00, op_b 1. Next WB.
  - LUI: op_a 10, op_b 1. Next WB.
  - AUIPC: op_a 01, op_b 1. Next WB.
  - LOAD and STORE: op_a 00, op_b 1. Next MEM.
  - JAL: op_a 01, op_b 1. Next WB.
  - JALR: op_a 00, op_b 1. Next WB.
  - BRANCH: op_a 01, op_b 1; o_pc_we = 1, o_pc_sel = i_br_taken; instruction retires; next FETCH.
- MEM:
  - o_dmem_req = 1; o_dmem_we = 1 only for STORE.
  - Operand selects are held from EXEC.
  - On i_dmem_ack with LOAD: next WB.
  - On i_dmem_ack with STORE: o_pc_we = 1, o_pc_sel = 0; instruction retires; next FETCH.
- WB:
  - o_rf_we = 1, o_pc_we = 1; operand selects held.
  - o_wb_sel = 01 for LOAD, 10 for JAL/JALR, 00 otherwise.
  - o_pc_sel = 1 for JAL/JALR, 0 otherwise.
  - Instruction retires; next FETCH.
- Retire: o_retired increments by 1 on each retiring cycle and wraps from 0xFFFFFFFF to 0.
- Wait counter (8-bit):
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle spent in FETCH or MEM without an ack.
  - Timeout condition: counter == MEM_TIMEOUT-1 and no ack. Next state TRAP with cause 10 (from FETCH) or 11 (from MEM).
  - An ack in the timeout cycle wins over the timeout.
- TRAP:
  - o_trap = 1; all other control outputs 0; o_trap_cause and o_retired frozen.
  - Exit only via reset.
- Ack outside its request state: ignored.
- Retire counts per instruction class:
  - Branch retires in 3 cycles after the ack cycle (FETCH, DECODE, EXEC).
  - ALU instructions retire in 4 (adds WB).
  - Loads retire in 5 with zero-wait memory.

Test Plan:
- Reset, then instruction ack present every cycle, i_opcode = 0110011 (OP): state sequence 0,1,2,3,5,1. o_rf_we = 1 only in WB. o_retired = 1 after the first WB.
- LOAD (0000011), i_dmem_ack delayed 3 cycles: o_dmem_req held for 4 cycles, o_dmem_we = 0. WB has o_wb_sel = 01 and o_imm_sel = 000.
- BRANCH (1100011) with i_br_taken = 1: EXEC has o_pc_we = 1, o_pc_sel = 1, o_imm_sel = 010, o_rf_we = 0. Next state FETCH.
- JAL (1101111): o_imm_sel = 100; WB has o_wb_sel = 10, o_pc_sel = 1.
- Opcode 1111111 in DECODE: TRAP, o_trap = 1, o_trap_cause = 01. Outputs frozen for 20 cycles; reset returns to IDLE with o_retired = 0.
- MEM_TIMEOUT = 4, i_imem_ack held low: TRAP with cause 10 after 4 FETCH cycles. Repeat with ack arriving on the 4th FETCH cycle: goes to DECODE, no trap. Then assert reset mid-MEM: state = 0 and o_dmem_req = 0 immediately.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Handshake and control bundle between the multi-cycle sequencer and the datapath/memories.
// The sequencer is the master; the datapath and memory side is the slave.
interface multicycle_ctrl_if;
    logic [6:0]  i_opcode;
    logic        i_imem_ack;
    logic        i_dmem_ack;
    logic        i_br_taken;
    logic        o_imem_req;
    logic        o_ir_we;
    logic        o_pc_we;
    logic        o_pc_sel;
    logic        o_rf_we;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [2:0]  o_imm_sel;
    logic [1:0]  o_op_a_sel;
    logic        o_op_b_sel;
    logic [1:0]  o_wb_sel;
    logic        o_trap;
    logic [1:0]  o_trap_cause;
    logic [31:0] o_retired;
    logic [2:0]  o_state;

    modport master (
        input  i_opcode, i_imem_ack, i_dmem_ack, i_br_taken,
        output o_imem_req, o_ir_we, o_pc_we, o_pc_sel, o_rf_we, o_dmem_req, o_dmem_we,
               o_imm_sel, o_op_a_sel, o_op_b_sel, o_wb_sel, o_trap, o_trap_cause,
               o_retired, o_state
    );

    modport slave (
        output i_opcode, i_imem_ack, i_dmem_ack, i_br_taken,
        input  o_imem_req, o_ir_we, o_pc_we, o_pc_sel, o_rf_we, o_dmem_req, o_dmem_we,
               o_imm_sel, o_op_a_sel, o_op_b_sel, o_wb_sel, o_trap, o_trap_cause,
               o_retired, o_state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RISC-V control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory-timeout and
// illegal-opcode traps and a retired-instruction counter.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic               i_clk,
    input  logic               i_reset,
    multicycle_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StTrap   = 3'd7
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpOp     = 7'b0110011;
    localparam logic [6:0] OpOpImm  = 7'b0010011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] retired_q, retired_d;
    logic        trap_q, trap_d;
    logic [1:0]  cause_q, cause_d;
    logic        retire;

    // Opcode decode, shared by every post-fetch state
    logic       legal, is_load, is_store, is_branch, is_jump;
    logic [2:0] imm_type;
    logic [1:0] op_a_type;
    logic       op_b_type;

    always_comb begin
        legal     = 1'b1;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        imm_type  = 3'b000;
        op_a_type = 2'b00;
        op_b_type = 1'b1;
        case (bus.i_opcode)
            OpOp:     op_b_type = 1'b0;
            OpOpImm:  ;
            OpLoad:   is_load = 1'b1;
            OpStore: begin
                is_store = 1'b1;
                imm_type = 3'b001;
            end
            OpBranch: begin
                is_branch = 1'b1;
                imm_type  = 3'b010;
                op_a_type = 2'b01;
            end
            OpLui: begin
                imm_type  = 3'b011;
                op_a_type = 2'b10;
            end
            OpAuipc: begin
                imm_type  = 3'b011;
                op_a_type = 2'b01;
            end
            OpJal: begin
                is_jump   = 1'b1;
                imm_type  = 3'b100;
                op_a_type = 2'b01;
            end
            OpJalr:   is_jump = 1'b1;
            default: begin
                legal     = 1'b0;
                op_b_type = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = 8'd0;
        cause_d        = cause_q;
        retire         = 1'b0;
        bus.o_imem_req = 1'b0;
        bus.o_ir_we    = 1'b0;
        bus.o_pc_we    = 1'b0;
        bus.o_pc_sel   = 1'b0;
        bus.o_rf_we    = 1'b0;
        bus.o_dmem_req = 1'b0;
        bus.o_dmem_we  = 1'b0;
        bus.o_imm_sel  = 3'b000;
        bus.o_op_a_sel = 2'b00;
        bus.o_op_b_sel = 1'b0;
        bus.o_wb_sel   = 2'b00;
        case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                bus.o_imem_req = 1'b1;
                if (bus.i_imem_ack) begin
                    bus.o_ir_we = 1'b1;
                    state_d     = StDecode;
                end else if (wait_cnt_q == TimeoutLast) begin
                    state_d = StTrap;
                    cause_d = 2'b10;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            StDecode: begin
                bus.o_imm_sel = imm_type;
                if (legal) begin
                    state_d = StExec;
                end else begin
                    state_d = StTrap;
                    cause_d = 2'b01;
                end
            end
            StExec: begin
                bus.o_imm_sel  = imm_type;
                bus.o_op_a_sel = op_a_type;
                bus.o_op_b_sel = op_b_type;
                if (is_branch) begin
                    bus.o_pc_we  = 1'b1;
                    bus.o_pc_sel = bus.i_br_taken;
                    retire       = 1'b1;
                    state_d      = StFetch;
                end else if (is_load || is_store) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                bus.o_imm_sel  = imm_type;
                bus.o_op_a_sel = op_a_type;
                bus.o_op_b_sel = op_b_type;
                bus.o_dmem_req = 1'b1;
                bus.o_dmem_we  = is_store;
                // An ack in the last allowed cycle still completes the access
                if (bus.i_dmem_ack) begin
                    if (is_store) begin
                        bus.o_pc_we = 1'b1;
                        retire      = 1'b1;
                        state_d     = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end else if (wait_cnt_q == TimeoutLast) begin
                    state_d = StTrap;
                    cause_d = 2'b11;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            StWb: begin
                bus.o_imm_sel  = imm_type;
                bus.o_op_a_sel = op_a_type;
                bus.o_op_b_sel = op_b_type;
                bus.o_rf_we    = 1'b1;
                bus.o_pc_we    = 1'b1;
                bus.o_pc_sel   = is_jump;
                bus.o_wb_sel   = is_load ? 2'b01 : (is_jump ? 2'b10 : 2'b00);
                retire         = 1'b1;
                state_d        = StFetch;
            end
            StTrap: state_d = StTrap;
            default: state_d = StIdle;
        endcase
    end

    assign retired_d = retired_q + {31'd0, retire};
    assign trap_d    = (state_d == StTrap);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= StIdle;
            wait_cnt_q <= 8'd0;
            retired_q  <= 32'd0;
            trap_q     <= 1'b0;
            cause_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            retired_q  <= retired_d;
            trap_q     <= trap_d;
            cause_q    <= cause_d;
        end
    end

    assign bus.o_trap       = trap_q;
    assign bus.o_trap_cause = cause_q;
    assign bus.o_retired    = retired_q;
    assign bus.o_state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each stimulus cycle queues its expected outputs and a
// mid-cycle monitor pops and compares them against the DUT.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [2:0]  st;
        logic [6:0]  strobes;  // imem_req, ir_we, pc_we, pc_sel, rf_we, dmem_req, dmem_we
        logic [2:0]  imm;
        logic [1:0]  opa;
        logic        opb;
        logic [1:0]  wb;
        logic        trap;
        logic [1:0]  cause;
        logic [31:0] ret;
    } outv_t;

    typedef struct {
        string name;
        outv_t exp;
    } sb_item_t;

    localparam logic [6:0] OP  = 7'b0110011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] ILL = 7'b1111111;

    localparam logic [2:0] SI = 3'd0, SF = 3'd1, SD = 3'd2, SE = 3'd3, SM = 3'd4, SW = 3'd5;
    localparam logic [2:0] STR = 3'd7;

    logic clk;
    logic i_reset;
    int   checks;
    int   errors;
    sb_item_t sbq[$];

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outv_t e(input logic [2:0] st, input logic [6:0] s, input logic [2:0] imm,
                                input logic [1:0] opa, input logic opb, input logic [1:0] wb,
                                input logic trap, input logic [1:0] cause,
                                input logic [31:0] ret);
        return {st, s, imm, opa, opb, wb, trap, cause, ret};
    endfunction

    // acks = {i_imem_ack, i_dmem_ack, i_br_taken}
    task automatic cyc(input string name, input logic rst, input logic [6:0] op,
                       input logic [2:0] acks, input outv_t exp);
        @(posedge clk);
        #1;
        i_reset        = rst;
        bus.i_opcode   = op;
        bus.i_imem_ack = acks[2];
        bus.i_dmem_ack = acks[1];
        bus.i_br_taken = acks[0];
        sbq.push_back('{name, exp});
    endtask

    always @(negedge clk) begin
        sb_item_t item;
        outv_t    act;
        if (sbq.size() > 0) begin
            item = sbq.pop_front();
            act = {bus.o_state, bus.o_imem_req, bus.o_ir_we, bus.o_pc_we, bus.o_pc_sel,
                   bus.o_rf_we, bus.o_dmem_req, bus.o_dmem_we, bus.o_imm_sel, bus.o_op_a_sel,
                   bus.o_op_b_sel, bus.o_wb_sel, bus.o_trap, bus.o_trap_cause, bus.o_retired};
            checks++;
            if (act !== item.exp) begin
                errors++;
                $display("FAIL %s @%0t: got st=%0d vec=%h, expected st=%0d vec=%h",
                         item.name, $time, act.st, act, item.exp.st, item.exp);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        i_reset        = 1'b1;
        bus.i_opcode   = OP;
        bus.i_imem_ack = 1'b0;
        bus.i_dmem_ack = 1'b0;
        bus.i_br_taken = 1'b0;

        // Reset, then OP with instruction ack every cycle
        cyc("reset",     1'b1, OP, 3'b100, e(SI, 7'b0, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0));
        cyc("idle",      1'b0, OP, 3'b100, e(SI, 7'b0, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0));
        cyc("op_fetch",  1'b0, OP, 3'b100, e(SF, 7'b1100000, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0));
        cyc("op_decode", 1'b0, OP, 3'b100, e(SD, 7'b0, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0));
        cyc("op_exec",   1'b0, OP, 3'b100, e(SE, 7'b0, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0));
        cyc("op_wb",     1'b0, OP, 3'b100, e(SW, 7'b0010100, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0));

        // LOAD, data ack on the 4th MEM cycle (the timeout cycle: ack wins); imem ack ignored in MEM
        cyc("ld_fetch",  1'b0, LD, 3'b100, e(SF, 7'b1100000, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd1));
        cyc("ld_decode", 1'b0, LD, 3'b100, e(SD, 7'b0, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd1));
        cyc("ld_exec",   1'b0, LD, 3'b100, e(SE, 7'b0, 3'd0, 2'd0, 1'b1, 2'd0, 1'b0, 2'd0, 32'd1));
        for (int i = 0; i < 3; i++)
            cyc("ld_mem_wait", 1'b0, LD, 3'b100,
                e(SM, 7'b0000010, 3'd0, 2'd0, 1'b1, 2'd0, 1'b0, 2'd0, 32'd1));
        cyc("ld_mem_ack", 1'b0, LD, 3'b110, e(SM, 7'b0000010, 3'd0, 2'd0, 1'b1, 2'd0, 1'b0, 2'd0, 32'd1));
        cyc("ld_wb",     1'b0, LD, 3'b100, e(SW, 7'b0010100, 3'd0, 2'd0, 1'b1, 2'd1, 1'b0, 2'd0, 32'd1));

        // BRANCH taken, then not taken
        cyc("brt_fetch", 1'b0, BR, 3'b101, e(SF, 7'b1100000, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd2));
        cyc("brt_decode", 1'b0, BR, 3'b101, e(SD, 7'b0, 3'd2, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd2));
        cyc("brt_exec",  1'b0, BR, 3'b101, e(SE, 7'b0011000, 3'd2, 2'd1, 1'b1, 2'd0, 1'b0, 2'd0, 32'd2));
        cyc("brn_fetch", 1'b0, BR, 3'b100, e(SF, 7'b1100000, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd3));
        cyc("brn_decode", 1'b0, BR, 3'b100, e(SD, 7'b0, 3'd2, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd3));
        cyc("brn_exec",  1'b0, BR, 3'b100, e(SE, 7'b0010000, 3'd2, 2'd1, 1'b1, 2'd0, 1'b0, 2'd0, 32'd3));

        // JAL
        cyc("jal_fetch", 1'b0, JAL, 3'b100, e(SF, 7'b1100000, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd4));
        cyc("jal_decode", 1'b0, JAL, 3'b100, e(SD, 7'b0, 3'd4, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd4));
        cyc("jal_exec",  1'b0, JAL, 3'b100, e(SE, 7'b0, 3'd4, 2'd1, 1'b1, 2'd0, 1'b0, 2'd0, 32'd4));
        cyc("jal_wb",    1'b0, JAL, 3'b100, e(SW, 7'b0011100, 3'd4, 2'd1, 1'b1, 2'd2, 1'b0, 2'd0, 32'd4));

        // STORE with zero-wait data memory
        cyc("st_fetch",  1'b0, ST, 3'b100, e(SF, 7'b1100000, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd5));
        cyc("st_decode", 1'b0, ST, 3'b100, e(SD, 7'b0, 3'd1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd5));
        cyc("st_exec",   1'b0, ST, 3'b100, e(SE, 7'b0, 3'd1, 2'd0, 1'b1, 2'd0, 1'b0, 2'd0, 32'd5));
        cyc("st_mem",    1'b0, ST, 3'b110, e(SM, 7'b0010011, 3'd1, 2'd0, 1'b1, 2'd0, 1'b0, 2'd0, 32'd5));

        // Instruction ack on the last allowed FETCH cycle, then an illegal opcode
        for (int i = 0; i < 3; i++)
            cyc("if_wait", 1'b0, ILL, 3'b000,
                e(SF, 7'b1000000, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd6));
        cyc("if_ack_last", 1'b0, ILL, 3'b100, e(SF, 7'b1100000, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd6));
        cyc("ill_decode", 1'b0, ILL, 3'b000, e(SD, 7'b0, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd6));
        for (int i = 0; i < 20; i++)
            cyc("ill_trap_hold", 1'b0, (i % 2 == 0) ? LD : JAL, 3'b111,
                e(STR, 7'b0, 3'd0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd1, 32'd6));

        // Reset out of TRAP, then instruction fetch timeout
        cyc("trap_reset", 1'b1, OP, 3'b000, e(SI, 7'b0, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0));
        cyc("idle2",     1'b0, OP, 3'b000, e(SI, 7'b0, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0));
        for (int i = 0; i < 4; i++)
            cyc("if_timeout_wait", 1'b0, OP, 3'b000,
                e(SF, 7'b1000000, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0));
        for (int i = 0; i < 2; i++)
            cyc("if_timeout_trap", 1'b0, OP, 3'b111,
                e(STR, 7'b0, 3'd0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd2, 32'd0));

        // Asynchronous reset in the middle of a data access
        cyc("rst3",      1'b1, LD, 3'b100, e(SI, 7'b0, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0));
        cyc("idle3",     1'b0, LD, 3'b100, e(SI, 7'b0, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0));
        cyc("mr_fetch",  1'b0, LD, 3'b100, e(SF, 7'b1100000, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0));
        cyc("mr_decode", 1'b0, LD, 3'b100, e(SD, 7'b0, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0));
        cyc("mr_exec",   1'b0, LD, 3'b100, e(SE, 7'b0, 3'd0, 2'd0, 1'b1, 2'd0, 1'b0, 2'd0, 32'd0));
        cyc("mr_mem",    1'b0, LD, 3'b000, e(SM, 7'b0000010, 3'd0, 2'd0, 1'b1, 2'd0, 1'b0, 2'd0, 32'd0));
        cyc("mem_reset", 1'b1, LD, 3'b000, e(SI, 7'b0, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0));
        cyc("idle4",     1'b0, LD, 3'b100, e(SI, 7'b0, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0));

        // Data memory timeout
        cyc("dt_fetch",  1'b0, LD, 3'b100, e(SF, 7'b1100000, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0));
        cyc("dt_decode", 1'b0, LD, 3'b100, e(SD, 7'b0, 3'd0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 32'd0));
        cyc("dt_exec",   1'b0, LD, 3'b100, e(SE, 7'b0, 3'd0, 2'd0, 1'b1, 2'd0, 1'b0, 2'd0, 32'd0));
        for (int i = 0; i < 4; i++)
            cyc("dt_mem_wait", 1'b0, LD, 3'b100,
                e(SM, 7'b0000010, 3'd0, 2'd0, 1'b1, 2'd0, 1'b0, 2'd0, 32'd0));
        for (int i = 0; i < 2; i++)
            cyc("dt_trap", 1'b0, LD, 3'b111,
                e(STR, 7'b0, 3'd0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd3, 32'd0));

        @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
